// File: rtl/vex_issue_sched_pkg.sv
// Shared vector-lane types: register index width, reservation slot and scheduler request.
package vex_issue_sched_pkg;
  localparam int VREG_IDX_W = 5;

  typedef logic [VREG_IDX_W-1:0] vreg_t;

  // One writeback reservation: valid, destination, and whether it is a multiplier result.
  typedef struct packed {
    logic  v;
    vreg_t dest;
    logic  mul;
  } slot_t;

  // Decoded micro-op as seen by the issue scheduler; src[0] is src1.
  typedef struct packed {
    vreg_t        dest;
    vreg_t [2:0]  src;
    logic  [2:0]  src_use;
    logic         is_mul;
  } sched_req_t;

  localparam slot_t SLOT_EMPTY = '0;
endpackage

// File: rtl/vex_issue_sched_vscoreboard.sv
// Register busy scoreboard: set/clear ports with set-wins priority and a hazard lookup.
module vscoreboard
  import vex_issue_sched_pkg::*;
#(
  parameter int NREG = 32,
  parameter int NSET = 2,
  parameter int NCLR = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSET-1:0]        set_valid,
  input  vreg_t [NSET-1:0]       set_idx,
  input  logic [NCLR-1:0]        clr_valid,
  input  vreg_t [NCLR-1:0]       clr_idx,
  input  sched_req_t             req,
  output logic                   raw,
  output logic                   waw,
  output logic [NREG-1:0]        busy
);
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // Decode the set and clear requests into register masks.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < NSET; i++)
      if (set_valid[i]) set_mask[set_idx[i]] = 1'b1;
    for (int i = 0; i < NCLR; i++)
      if (clr_valid[i]) clr_mask[clr_idx[i]] = 1'b1;
  end

  // Busy register; a set on the same register as a clear leaves it busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= (busy & ~clr_mask) | set_mask;
  end

  // Hazard lookup: any read source busy (RAW), or the destination busy (WAW).
  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < 3; i++)
      if (req.src_use[i] && busy[req.src[i]]) raw = 1'b1;
    waw = busy[req.dest];
  end
endmodule

// File: rtl/vex_issue_sched.sv
// Issue scheduler for one vector lane: hazard stall, writeback port reservation, stall counter.
module vex_issue_sched
  import vex_issue_sched_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int NREG    = 32,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_dest,
  input  logic [14:0]           in_src,
  input  logic [2:0]            in_src_use,
  input  logic                  in_is_mul,
  output logic                  issue_valid,
  input  logic                  ld_valid,
  input  logic [4:0]            ld_dest,
  input  logic                  ld_wb_valid,
  input  logic [4:0]            ld_wb_dest,
  output logic                  wb_valid,
  output logic [4:0]            wb_dest,
  output logic                  wb_is_mul,
  output logic [NREG-1:0]       busy,
  output logic [CNT_W-1:0]      stall_cnt
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  sched_req_t req;
  logic       raw, waw, port;

  // line[k] holds the writeback due k cycles from now. The farthest slot
  // (MUL_LAT) is only ever filled by a mul issuing this cycle, so it needs no
  // register: eff[] is the line as seen this cycle with any new issue overlaid.
  slot_t line [1:MUL_LAT-1];
  slot_t eff  [1:MUL_LAT];

  assign req = '{dest: in_dest, src: in_src, src_use: in_src_use, is_mul: in_is_mul};

  vscoreboard #(.NREG(NREG), .NSET(2), .NCLR(2)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_valid ({ld_valid, issue_valid}),
    .set_idx   ({ld_dest, in_dest}),
    .clr_valid ({ld_wb_valid, wb_valid}),
    .clr_idx   ({ld_wb_dest, wb_dest}),
    .req       (req),
    .raw       (raw),
    .waw       (waw),
    .busy      (busy)
  );

  // An ALU op writes next cycle, so it collides with anything already due then.
  assign port        = !in_is_mul && line[1].v;
  assign in_ready    = !(in_valid && (raw || waw || port));
  assign issue_valid = in_valid && in_ready;

  // Overlay this cycle's issue onto the reservation line.
  always_comb begin
    for (int k = 1; k < MUL_LAT; k++) eff[k] = line[k];
    eff[MUL_LAT] = SLOT_EMPTY;
    if (issue_valid) begin
      if (in_is_mul) eff[MUL_LAT] = '{v: 1'b1, dest: in_dest, mul: 1'b1};
      else           eff[1]       = '{v: 1'b1, dest: in_dest, mul: 1'b0};
    end
  end

  // Advance the line one slot per cycle; the nearest slot becomes the writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k < MUL_LAT; k++) line[k] <= SLOT_EMPTY;
      wb_valid  <= 1'b0;
      wb_dest   <= '0;
      wb_is_mul <= 1'b0;
    end else begin
      for (int k = 1; k < MUL_LAT; k++) line[k] <= eff[k+1];
      wb_valid  <= eff[1].v;
      wb_dest   <= eff[1].dest;
      wb_is_mul <= eff[1].mul;
    end
  end

  // Saturating count of cycles where an offered op was held off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        stall_cnt <= '0;
    else if (in_valid && !in_ready && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
  end
endmodule

// File: tb/tb_vex_issue_sched.sv
// Self-checking bench for vex_issue_sched: directed tables, reset corner, random vs. model.
module tb_vex_issue_sched;
  localparam int MUL_LAT = 4;

  logic        clk, rst;
  logic        in_valid, in_ready, in_is_mul, issue_valid;
  logic [4:0]  in_dest, ld_dest, ld_wb_dest, wb_dest;
  logic [14:0] in_src;
  logic [2:0]  in_src_use;
  logic        ld_valid, ld_wb_valid, wb_valid, wb_is_mul;
  logic [31:0] busy, stall_cnt;

  vex_issue_sched #(.MUL_LAT(MUL_LAT), .NREG(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest),
    .in_src(in_src), .in_src_use(in_src_use), .in_is_mul(in_is_mul), .issue_valid(issue_valid),
    .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_wb_valid(ld_wb_valid), .ld_wb_dest(ld_wb_dest),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_is_mul(wb_is_mul), .busy(busy),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        rs;
    bit        iv;
    bit [4:0]  d;
    bit [14:0] s;
    bit [2:0]  u;
    bit        m;
    bit        lv;
    bit [4:0]  ld;
    bit        lwv;
    bit [4:0]  lwd;
    bit        er;
    bit        ewv;
    bit [4:0]  ewd;
    bit        ewm;
    int        es;
  } vec_t;

  int checks = 0;
  int fails  = 0;

  // Reference model: busy bit set, writebacks booked by absolute cycle number.
  bit [31:0] m_busy;
  int        m_cyc;
  int        pd[int];
  bit        pm[int];
  longint    m_stall;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, m_cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = '0; m_cyc = 0; m_stall = 0;
    pd.delete(); pm.delete();
  endtask

  task automatic drive_idle();
    in_valid = 0; in_dest = 0; in_src = 0; in_src_use = 0; in_is_mul = 0;
    ld_valid = 0; ld_dest = 0; ld_wb_valid = 0; ld_wb_dest = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_dest", wb_dest, 0);
    chk("rst_wb_is_mul", wb_is_mul, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one cycle, compare against the model (and the table row when hand=1), advance.
  task automatic run_cycle(input vec_t v, input bit hand);
    bit raw, port, eready, issue, ewv, ewm, wbclr;
    bit [4:0] ewd, sidx;
    bit [31:0] clr, set;
    in_valid = v.iv; in_dest = v.d; in_src = v.s; in_src_use = v.u; in_is_mul = v.m;
    ld_valid = v.lv; ld_dest = v.ld; ld_wb_valid = v.lwv; ld_wb_dest = v.lwd;
    @(negedge clk);
    raw = 0;
    for (int i = 0; i < 3; i++) begin
      sidx = v.s[i*5 +: 5];
      if (v.u[i] && m_busy[sidx]) raw = 1;
    end
    port   = !v.m && pd.exists(m_cyc + 1);
    eready = !(v.iv && (raw || m_busy[v.d] || port));
    issue  = v.iv && eready;
    ewv    = pd.exists(m_cyc);
    ewd    = ewv ? 5'(pd[m_cyc]) : 5'd0;
    ewm    = ewv ? pm[m_cyc] : 1'b0;
    chk("in_ready", in_ready, eready);
    chk("issue_valid", issue_valid, issue);
    chk("wb_valid", wb_valid, ewv);
    if (ewv) begin
      chk("wb_dest", wb_dest, ewd);
      chk("wb_is_mul", wb_is_mul, ewm);
    end
    chk("busy", busy, m_busy);
    chk("stall_cnt", stall_cnt, m_stall);
    if (hand) begin
      chk("tbl_in_ready", in_ready, v.er);
      chk("tbl_wb_valid", wb_valid, v.ewv);
      if (v.ewv) begin
        chk("tbl_wb_dest", wb_dest, v.ewd);
        chk("tbl_wb_is_mul", wb_is_mul, v.ewm);
      end
      if (v.es >= 0) chk("tbl_stall_cnt", stall_cnt, v.es);
    end
    @(posedge clk);
    wbclr = ewv;
    clr = '0; set = '0;
    if (wbclr) clr[ewd] = 1'b1;
    if (v.lwv) clr[v.lwd] = 1'b1;
    if (issue) begin
      set[v.d] = 1'b1;
      pd[m_cyc + (v.m ? MUL_LAT : 1)] = v.d;
      pm[m_cyc + (v.m ? MUL_LAT : 1)] = v.m;
    end
    if (v.lv) set[v.ld] = 1'b1;
    m_busy = (m_busy & ~clr) | set;
    if (v.iv && !eready && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (ewv) begin pd.delete(m_cyc); pm.delete(m_cyc); end
    m_cyc++;
    #1;
  endtask

  function automatic vec_t mkv(input bit rs, iv, input int d, s1, input bit [2:0] u,
                               input bit m, lv, input int ld, input bit lwv, input int lwd,
                               input bit er, ewv, input int ewd, input bit ewm, input int es);
    vec_t v;
    v.rs = rs; v.iv = iv; v.d = 5'(d); v.s = {10'd0, 5'(s1)}; v.u = u; v.m = m;
    v.lv = lv; v.ld = 5'(ld); v.lwv = lwv; v.lwd = 5'(lwd);
    v.er = er; v.ewv = ewv; v.ewd = 5'(ewd); v.ewm = ewm; v.es = es;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", m_cyc);
    $fatal(1);
  end

  initial begin
    vec_t v, idle;
    rst = 1'b1;
    drive_idle();
    idle = mkv(0,0,0,0,3'b000,0,0,0,0,0, 1,0,0,0,-1);

    // Port conflict: mul v3 at 0, ALU v5<-v1 blocked at 3, issues at 4.
    tbl.push_back(mkv(1,1,3,0,3'b000,1,0,0,0,0, 1,0,0,0,-1));
    tbl.push_back(idle);
    tbl.push_back(idle);
    tbl.push_back(mkv(0,1,5,1,3'b001,0,0,0,0,0, 0,0,0,0,-1));
    tbl.push_back(mkv(0,1,5,1,3'b001,0,0,0,0,0, 1,1,3,1,-1));
    tbl.push_back(mkv(0,0,0,0,3'b000,0,0,0,0,0, 1,1,5,0,-1));
    tbl.push_back(idle);
    // RAW on ALU result: two-cycle dependency distance, one stall cycle.
    tbl.push_back(mkv(1,1,2,0,3'b000,0,0,0,0,0, 1,0,0,0,-1));
    tbl.push_back(mkv(0,1,6,2,3'b001,0,0,0,0,0, 0,1,2,0,-1));
    tbl.push_back(mkv(0,1,6,2,3'b001,0,0,0,0,0, 1,0,0,0, 1));
    tbl.push_back(mkv(0,0,0,0,3'b000,0,0,0,0,0, 1,1,6,0, 1));
    // Back-to-back muls.
    tbl.push_back(mkv(1,1,1,0,3'b000,1,0,0,0,0, 1,0,0,0,-1));
    tbl.push_back(mkv(0,1,2,0,3'b000,1,0,0,0,0, 1,0,0,0,-1));
    tbl.push_back(mkv(0,1,3,0,3'b000,1,0,0,0,0, 1,0,0,0,-1));
    tbl.push_back(idle);
    tbl.push_back(mkv(0,0,0,0,3'b000,0,0,0,0,0, 1,1,1,1,-1));
    tbl.push_back(mkv(0,0,0,0,3'b000,0,0,0,0,0, 1,1,2,1,-1));
    tbl.push_back(mkv(0,0,0,0,3'b000,0,0,0,0,0, 1,1,3,1, 0));
    tbl.push_back(idle);
    // Load v7 busy from 0 to 6; consumer stalls 1..6, issues 7.
    tbl.push_back(mkv(1,0,0,0,3'b000,0,1,7,0,0, 1,0,0,0,-1));
    for (int i = 1; i <= 5; i++) tbl.push_back(mkv(0,1,8,7,3'b001,0,0,0,0,0, 0,0,0,0,-1));
    tbl.push_back(mkv(0,1,8,7,3'b001,0,0,0,1,7, 0,0,0,0, 5));
    tbl.push_back(mkv(0,1,8,7,3'b001,0,0,0,0,0, 1,0,0,0, 6));
    tbl.push_back(mkv(0,0,0,0,3'b000,0,0,0,0,0, 1,1,8,0, 6));
    // Load set coinciding with the ALU writeback of v4: v4 stays busy.
    tbl.push_back(mkv(1,1,4,0,3'b000,0,0,0,0,0, 1,0,0,0,-1));
    tbl.push_back(mkv(0,0,0,0,3'b000,0,1,4,0,0, 1,1,4,0,-1));
    tbl.push_back(mkv(0,1,11,4,3'b001,0,0,0,0,0, 0,0,0,0,-1));
    tbl.push_back(mkv(0,1,11,4,3'b001,0,0,0,1,4, 0,0,0,0,-1));
    tbl.push_back(mkv(0,1,11,4,3'b001,0,0,0,0,0, 1,0,0,0, 2));
    tbl.push_back(mkv(0,0,0,0,3'b000,0,0,0,0,0, 1,1,11,0,-1));

    foreach (tbl[i]) begin
      if (tbl[i].rs) reset_dut();
      run_cycle(tbl[i], 1'b1);
    end

    // Reset while a mul is in flight and an ALU writeback is on the port.
    reset_dut();
    run_cycle(mkv(0,1,9,0,3'b000,1,0,0,0,0, 1,0,0,0,-1), 1'b1);
    run_cycle(mkv(0,1,10,0,3'b000,0,0,0,0,0, 1,0,0,0,-1), 1'b1);
    drive_idle();
    @(negedge clk);
    chk("pre_rst_wb_valid", wb_valid, 1);
    chk("pre_rst_busy", busy, 32'h0000_0600);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wb_valid", wb_valid, 0);
    chk("mid_rst_stall_cnt", stall_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) run_cycle(idle, 1'b0);

    // Randomized traffic on a small register window to provoke hazards.
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      v = idle;
      v.iv  = ($urandom % 4) != 0;
      v.d   = 5'($urandom_range(0, 7));
      v.s   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      v.u   = 3'($urandom);
      v.m   = ($urandom % 3) == 0;
      v.lv  = ($urandom % 8) == 0;
      v.ld  = 5'($urandom_range(0, 7));
      v.lwv = ($urandom % 5) == 0;
      v.lwd = 5'($urandom_range(0, 7));
      run_cycle(v, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/vex_issue_sched.md
Name: vex_issue_sched

Overview:
- Issue scheduler in front of one vector lane's execution stage.
- Accepts decoded micro-ops through a valid/ready handshake and tracks register hazards with a 32-entry busy scoreboard.
- Reserves the single lane writeback port so that single-cycle ALU results never collide with multi-cycle multiply results.
- Emits a predicted writeback strobe, destination and source select (ALU or multiplier) for the lane writeback mux.

Parameters:
- MUL_LAT, 4, cycles from multiply issue to its writeback cycle (>=2).
- NREG, 32, number of vector registers; register index width is $clog2(NREG) = 5.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  upstream micro-op valid
- in_ready  out  1  scheduler can accept this cycle (combinational)
- in_dest  in  5  destination register
- in_src  in  15  three source register indices {src3,src2,src1}
- in_src_use  in  3  per-source "operand read" flags
- in_is_mul  in  1  op uses the multiplier path
- issue_valid  out  1  = in_valid & in_ready; op enters the lane this cycle
- ld_valid  in  1  load issued elsewhere, marks ld_dest busy
- ld_dest  in  5  load destination register
- ld_wb_valid  in  1  load data written (separate load port)
- ld_wb_dest  in  5  load writeback register
- wb_valid  out  1  lane writeback occurs this cycle (registered)
- wb_dest  out  5  register written this cycle
- wb_is_mul  out  1  writeback mux select, 1 = multiplier result
- busy  out  32  scoreboard vector, bit i = register i pending
- stall_cnt  out  CNT_W  saturating count of cycles with in_valid & !in_ready

Behaviour:
- Reset: busy=0, reservation slots empty, wb_valid=0, wb_dest=0, wb_is_mul=0, stall_cnt=0.
  - in_ready is combinational and equals 1 after reset when no hazard exists.
- Reset mid-operation discards all in-flight tracking. Ops already in the lane may still complete in hardware; the upstream is flushed alongside, so this is legal.
- Reservation line: slot[1..MUL_LAT], each holding {v, dest, mul}. slot[k].v = 1 means a writeback occurs k cycles after the current cycle.
- Shift every cycle: slot[k] <= slot[k+1]; slot[MUL_LAT] <= empty, unless a mul issues.
- Issue at cycle t:
  - Non-mul op: inserted into slot[1] (writeback in cycle t+1).
  - Mul op: inserted into slot[MUL_LAT] (writeback in cycle t+MUL_LAT).
- wb_valid/wb_dest/wb_is_mul are registered from slot[1] at each edge. They are asserted exactly in the writeback cycle.
- in_ready = !(raw | waw | port). Each hazard term requires in_valid.
  - raw: any source i with in_src_use[i] and busy[src_i].
  - waw: busy[in_dest].
  - port: !in_is_mul & slot[1].v. A mul writes next cycle, so the ALU op stalls.
- Muls never conflict with each other (one per cycle, distinct slots) and may issue back-to-back.
- Scoreboard updates at each edge:
  - Set busy[in_dest] on issue.
  - Set busy[ld_dest] on ld_valid.
  - Clear busy[wb_dest] at the end of a cycle in which wb_valid=1.
  - Clear busy[ld_wb_dest] on ld_wb_valid.
- Same-register set and clear in the same cycle: set wins.
  - Cannot occur from issue, because of the WAW check.
  - Can occur from ld_valid; the load stays busy.
- No bypass: a dependent op issues in the cycle after its producer's writeback cycle. ALU-to-ALU dependency distance is therefore 2 cycles.
- ld_valid and ld_wb_valid never use the lane writeback port and never block the port check.
- stall_cnt increments on in_valid & !in_ready and saturates at all-ones.

Decomposition:
- Add to the shared vector package:
  - a slot struct {v, dest[4:0], mul}
  - a scheduler request struct {dest, src[3], src_use, is_mul}
  - the constant VREG_IDX_W = 5
- One natural sub-module, vscoreboard: a NREG-bit busy register with set/clear ports, set-wins priority, and a 3-source plus 1-dest hazard lookup.
- The reservation line and the counter stay in vex_issue_sched.

Test Plan (MUL_LAT=4):
- Reset release -> busy=0, wb_valid=0, stall_cnt=0. An op with in_valid=1 and an idle scoreboard sees in_ready=1 in the first cycle.
- Mul to v3 at cycle 0; ALU v5<-v1 offered at cycle 3 -> in_ready=0 at cycle 3 (port), issues cycle 4. Writebacks: v3 at cycle 4 (wb_is_mul=1), v5 at cycle 5.
- ALU v2 issues cycle 0; dependent op reading v2 offered from cycle 1 -> stalls cycle 1 and issues cycle 2. stall_cnt=1.
- Muls v1, v2, v3 at cycles 0, 1, 2 -> all accepted. wb_dest = 1, 2, 3 in cycles 4, 5, 6 with wb_is_mul=1.
- ld_valid v7 at cycle 0, ld_wb_valid v7 at cycle 6; consumer of v7 offered from cycle 1 -> in_ready=0 through cycle 6, issues cycle 7.
- ld_valid v4 coincides with the wb_valid cycle for v4 -> busy[4] stays 1. Asserting rst mid-mul -> busy=0 and wb_valid=0 immediately.
